instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 76 +++++++
 rtl/instr_encoder_fifo.sv | 61 ++++++
 rtl/instr_encoder.sv | 86 ++++++++
 tb/tb_instr_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder.
// Holds the instruction class codes (the same numbering the decoder emits),
// the branch condition codes, the instruction width, the encoder FSM state
// type, and the helpers that check a class and assemble an instruction word.
package instr_encoder_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CLASS_W = 7;

  localparam logic [CLASS_W-1:0] CLS_MOV_IMM8  = 7'd1;
  localparam logic [CLASS_W-1:0] CLS_MOV_RD_RM = 7'd2;
  localparam logic [CLASS_W-1:0] CLS_ADD       = 7'd3;
  localparam logic [CLASS_W-1:0] CLS_CMP       = 7'd4;
  localparam logic [CLASS_W-1:0] CLS_AND       = 7'd5;
  localparam logic [CLASS_W-1:0] CLS_MVN       = 7'd6;
  localparam logic [CLASS_W-1:0] CLS_LDR       = 7'd7;
  localparam logic [CLASS_W-1:0] CLS_STR       = 7'd8;
  localparam logic [CLASS_W-1:0] CLS_HALT      = 7'd9;
  localparam logic [CLASS_W-1:0] CLS_B         = 7'd10;
  localparam logic [CLASS_W-1:0] CLS_EQ        = 7'd11;
  localparam logic [CLASS_W-1:0] CLS_NE        = 7'd12;
  localparam logic [CLASS_W-1:0] CLS_LT        = 7'd13;
  localparam logic [CLASS_W-1:0] CLS_LE        = 7'd14;
  localparam logic [CLASS_W-1:0] CLS_BL        = 7'd15;
  localparam logic [CLASS_W-1:0] CLS_BX        = 7'd16;
  localparam logic [CLASS_W-1:0] CLS_BLX       = 7'd17;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  function automatic logic is_legal(input logic [CLASS_W-1:0] cls);
    return (cls >= CLS_MOV_IMM8) && (cls <= CLS_BLX);
  endfunction

  function automatic logic [INSTR_W-1:0] encode(
    input logic [CLASS_W-1:0] cls,
    input logic [2:0]         rd,
    input logic [2:0]         rn,
    input logic [2:0]         rm,
    input logic [1:0]         sh,
    input logic [7:0]         imm8
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    case (cls)
      CLS_MOV_IMM8:  w = {3'b110, 2'b10, rn, imm8};
      CLS_MOV_RD_RM: w = {3'b110, 2'b00, 3'b000, rd, sh, rm};
      CLS_ADD:       w = {3'b101, 2'b00, rn, rd, sh, rm};
      CLS_CMP:       w = {3'b101, 2'b01, rn, 3'b000, sh, rm};
      CLS_AND:       w = {3'b101, 2'b10, rn, rd, sh, rm};
      CLS_MVN:       w = {3'b101, 2'b11, 3'b000, rd, sh, rm};
      CLS_LDR:       w = {3'b011, 2'b00, rn, rd, imm8[4:0]};
      CLS_STR:       w = {3'b100, 2'b00, rn, rd, imm8[4:0]};
      CLS_HALT:      w = 16'hE000;
      CLS_B:         w = {3'b001, 2'b00, COND_AL, imm8};
      CLS_EQ:        w = {3'b001, 2'b00, COND_EQ, imm8};
      CLS_NE:        w = {3'b001, 2'b00, COND_NE, imm8};
      CLS_LT:        w = {3'b001, 2'b00, COND_LT, imm8};
      CLS_LE:        w = {3'b001, 2'b00, COND_LE, imm8};
      CLS_BL:        w = {3'b010, 2'b11, 3'b111, imm8};
      CLS_BX:        w = {3'b010, 2'b00, 3'b000, rd, 5'b00000};
      CLS_BLX:       w = {3'b010, 2'b10, 3'b111, rd, 5'b00000};
      default:       w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Output FIFO for encoded instructions.
// Ports: clk, Reset_n (sync, active-low), push/wdata write side, pop/rdata
// read side (rdata is the registered head entry), clear empties the queue,
// full/empty/count status. Pointers wrap naturally since DEPTH is a power
// of two.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts class + operand requests, assembles 16-bit
// instruction words and queues them in an output FIFO.
// Ports: clk, Reset_n (sync, active-low); request side in_valid/in_ready,
// in_class, in_rd/in_rn/in_rm, in_sh, in_imm8; output side out_valid,
// out_ready, out_instr; err_illegal pulse and saturating err_count for
// rejected classes; halted status; flush clears the FIFO and resumes RUN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic [2:0]         in_rd,
  input  logic [2:0]         in_rn,
  input  logic [2:0]         in_rm,
  input  logic [1:0]         in_sh,
  input  logic [7:0]         in_imm8,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               err_illegal,
  output logic [7:0]         err_count,
  output logic               halted,
  input  logic               flush
);

  state_t               state;
  logic                 accept;
  logic                 legal;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [$clog2(DEPTH):0] count;
  logic [INSTR_W-1:0]   word;

  assign legal    = is_legal(in_class);
  assign word     = encode(in_class, in_rd, in_rn, in_rm, in_sh, in_imm8);
  assign in_ready = (state == ST_RUN) && !full;
  assign accept   = in_valid && in_ready;
  // Flush wins over everything, so both FIFO ports are gated by it here.
  assign push     = accept && legal && !flush;
  assign pop      = out_ready && !empty && !flush;
  assign out_valid = (count != '0);
  assign halted   = (state == ST_HALTED);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .Reset_n (Reset_n),
    .push    (push),
    .wdata   (word),
    .pop     (pop),
    .clear   (flush),
    .rdata   (out_instr),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state       <= ST_RUN;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else if (flush) begin
      state       <= ST_RUN;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && !legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      case (state)
        ST_RUN:     if (push && (in_class == CLS_HALT)) state <= ST_HALTED;
        ST_HALTED:  state <= ST_HALTED;
        default:    state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  localparam int C_MOVI = 1,  C_MOVR = 2,  C_ADD = 3,  C_CMP = 4,  C_AND = 5;
  localparam int C_MVN  = 6,  C_LDR  = 7,  C_STR = 8,  C_HALT = 9, C_B = 10;
  localparam int C_LE   = 14, C_BL   = 15, C_BX  = 16, C_BLX = 17;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_class;
  logic [2:0] in_rd, in_rn, in_rm;
  logic [1:0] in_sh;
  logic [7:0] in_imm8;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_instr;
  logic       err_illegal;
  logic [7:0] err_count;
  logic       halted;
  logic       flush;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int  m_q[$];
  bit  m_halt;
  int  m_errc;
  bit  m_errp;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .Reset_n     (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_rd       (in_rd),
    .in_rn       (in_rn),
    .in_rm       (in_rm),
    .in_sh       (in_sh),
    .in_imm8     (in_imm8),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .err_illegal (err_illegal),
    .err_count   (err_count),
    .halted      (halted),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word built from field positions with plain arithmetic.
  function automatic int ref_word(int cls, int rd, int rn, int rm, int sh, int imm);
    int reg3 = rd * 32 + sh * 8 + rm;
    case (cls)
      C_MOVI: return 'hD000 + rn * 256 + imm;
      C_MOVR: return 'hC000 + reg3;
      C_ADD:  return 'hA000 + rn * 256 + reg3;
      C_CMP:  return 'hA800 + rn * 256 + sh * 8 + rm;
      C_AND:  return 'hB000 + rn * 256 + reg3;
      C_MVN:  return 'hB800 + reg3;
      C_LDR:  return 'h6000 + rn * 256 + rd * 32 + (imm % 32);
      C_STR:  return 'h8000 + rn * 256 + rd * 32 + (imm % 32);
      C_HALT: return 'hE000;
      C_BL:   return 'h5F00 + imm;
      C_BX:   return 'h4000 + rd * 32;
      C_BLX:  return 'h5700 + rd * 32;
      default: begin
        if (cls >= C_B && cls <= C_LE) return 'h2000 + (cls - C_B) * 256 + imm;
        return 0;
      end
    endcase
  endfunction

  task automatic set_req(input int cls, input int rd, input int rn, input int rm,
                         input int sh, input int imm);
    in_valid = 1'b1;
    in_class = 7'(cls);
    in_rd    = 3'(rd);
    in_rn    = 3'(rn);
    in_rm    = 3'(rm);
    in_sh    = 2'(sh);
    in_imm8  = 8'(imm);
  endtask

  // Advance one clock: update the model from the current inputs, then
  // compare every output #1 after the edge.
  task automatic cycle();
    bit rdy, acc, lg;
    int cls;
    cls = int'(in_class);
    rdy = !m_halt && (m_q.size() < DEPTH);
    lg  = (cls >= 1) && (cls <= 17);
    if (!rst_n) begin
      m_q.delete(); m_halt = 0; m_errc = 0; m_errp = 0;
    end else if (flush) begin
      m_q.delete(); m_halt = 0; m_errp = 0;
    end else begin
      acc = in_valid && rdy;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc && lg) begin
        m_q.push_back(ref_word(cls, in_rd, in_rn, in_rm, in_sh, in_imm8));
        if (cls == C_HALT) m_halt = 1;
      end
      m_errp = acc && !lg;
      if (acc && !lg && m_errc < 255) m_errc++;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_instr", 32'(out_instr), 32'(m_q[0]));
    check("err_illegal", 32'(err_illegal), 32'(m_errp));
    check("err_count", 32'(err_count), 32'(m_errc));
    check("halted", 32'(halted), 32'(m_halt));
    check("in_ready", 32'(in_ready), 32'(!m_halt && m_q.size() < DEPTH));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_class = '0; in_rd = '0; in_rn = '0; in_rm = '0;
    in_sh = '0; in_imm8 = '0;
    m_halt = 0; m_errc = 0; m_errp = 0;

    // Reset state
    cycle(); cycle();
    check("rst_out_instr", 32'(out_instr), 32'h0000);
    check("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    cycle();

    // ADD example
    out_ready = 1'b1;
    set_req(C_ADD, 2, 1, 3, 1, 0);
    cycle();
    in_valid = 1'b0;
    check("add_word", 32'(out_instr), 32'hA14B);
    check("add_valid", 32'(out_valid), 1);
    cycle();

    // MOV_imm8, BL, BLX sequence
    set_req(C_MOVI, 0, 0, 0, 0, 8'h07); cycle();
    check("seq0", 32'(out_instr), 32'hD007);
    set_req(C_BL, 0, 0, 0, 0, 8'h10);   cycle();
    check("seq1", 32'(out_instr), 32'h5F10);
    set_req(C_BLX, 7, 0, 0, 0, 0);      cycle();
    check("seq2", 32'(out_instr), 32'h57E0);
    in_valid = 1'b0;
    cycle();

    // Back-pressure: six requests, four accepted
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(C_AND, i % 8, (i + 1) % 8, (i + 2) % 8, i % 4, 0);
      if (in_ready) n++;
      cycle();
    end
    check("accepted4", 32'(n), 4);
    check("full_not_ready", 32'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    set_req(C_CMP, 0, 5, 6, 2, 0);
    cycle();
    check("push_pop_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("drained", 32'(out_valid), 0);

    // Illegal class
    set_req(45, 0, 0, 0, 0, 0); cycle();
    check("illegal_pulse", 32'(err_illegal), 1);
    check("illegal_nopush", 32'(out_valid), 0);
    in_valid = 1'b0; cycle();
    check("illegal_pulse_end", 32'(err_illegal), 0);
    check("illegal_count1", 32'(err_count), 1);
    set_req(45, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle();
    in_valid = 1'b0; cycle();
    check("err_sat", 32'(err_count), 255);

    // HALT then flush
    out_ready = 1'b0;
    set_req(C_HALT, 0, 0, 0, 0, 0); cycle();
    in_valid = 1'b0;
    check("halt_word", 32'(out_instr), 32'hE000);
    check("halt_state", 32'(halted), 1);
    check("halt_not_ready", 32'(in_ready), 0);
    cycle();
    flush = 1'b1; cycle(); flush = 1'b0;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_halted", 32'(halted), 0);
    check("flush_ready", 32'(in_ready), 1);
    check("flush_keeps_err", 32'(err_count), 255);

    // Reset while three words are queued
    for (int i = 0; i < 3; i++) begin
      set_req(C_STR, i, i + 1, 0, 0, 8'h1F); cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("rst_q_valid", 32'(out_valid), 0);
    check("rst_q_err", 32'(err_count), 0);
    check("rst_q_ready", 32'(in_ready), 1);
    check("rst_q_instr", 32'(out_instr), 32'h0000);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r = $urandom_range(0, 99);
      int cls;
      if (r < 80)      cls = $urandom_range(1, 17);
      else if (r < 95) cls = $urandom_range(18, 127);
      else             cls = 0;
      set_req(cls, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 255));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
